// File: rtl/ddr_mgr_pkg.sv
// Shared types and defaults for the DDR2 manager request arbiter.
package ddr_mgr_pkg;

  localparam int unsigned DDR_ADDR_W        = 24;
  localparam int unsigned DDR_LEN_W         = 8;
  localparam int unsigned DDR_WR_STARVE_MAX = 64;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_XFER  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/ddr_req_arbiter_if.sv
// Requester, MIG command and beat signals between the arbiter and its neighbours.
interface ddr_req_arbiter_if
  import ddr_mgr_pkg::*;
#(
  parameter int unsigned ADDR_W = DDR_ADDR_W,
  parameter int unsigned LEN_W  = DDR_LEN_W
);

  logic              init_done;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [LEN_W-1:0]  rd_len;
  logic              rd_gnt;
  logic              rd_done;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [LEN_W-1:0]  wr_len;
  logic              wr_gnt;
  logic              wr_done;
  logic              cmd_valid;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              cmd_ready;
  logic              xfr_beat;
  logic              busy;

  modport slave (
    input  init_done, rd_req, rd_addr, rd_len, wr_req, wr_addr, wr_len,
           cmd_ready, xfr_beat,
    output rd_gnt, rd_done, wr_gnt, wr_done, cmd_valid, cmd_write,
           cmd_addr, cmd_len, busy
  );

  modport master (
    output init_done, rd_req, rd_addr, rd_len, wr_req, wr_addr, wr_len,
           cmd_ready, xfr_beat,
    input  rd_gnt, rd_done, wr_gnt, wr_done, cmd_valid, cmd_write,
           cmd_addr, cmd_len, busy
  );

endinterface

// File: rtl/ddr_req_prio.sv
// Read-priority winner selection with a write starvation guard.
module ddr_req_prio
  import ddr_mgr_pkg::*;
#(
  parameter int unsigned WR_STARVE_MAX = DDR_WR_STARVE_MAX
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rd_req,
  input  logic wr_req,
  input  logic idle,
  input  logic wr_gnt,
  output logic sel_rd,
  output logic sel_wr
);

  localparam int unsigned CNT_W = $clog2(WR_STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WR_STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt;
  logic             starved;

  // Count cycles a write has waited; saturate so the guard stays asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!wr_req || wr_gnt) begin
      starve_cnt <= '0;
    end else if (starve_cnt != CNT_MAX) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  assign starved = (starve_cnt >= CNT_MAX);

  // Pick the winner; reads win ties unless the write has starved.
  always_comb begin
    sel_rd = 1'b0;
    sel_wr = 1'b0;
    if (idle) begin
      if (wr_req && (!rd_req || starved)) begin
        sel_wr = 1'b1;
      end else if (rd_req) begin
        sel_rd = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ddr_req_arbiter.sv
// Grants one DDR2 requester at a time, issues its burst to the MIG and
// reports completion once the last data beat has been seen.
module ddr_req_arbiter
  import ddr_mgr_pkg::*;
#(
  parameter int unsigned ADDR_W        = DDR_ADDR_W,
  parameter int unsigned LEN_W         = DDR_LEN_W,
  parameter int unsigned WR_STARVE_MAX = DDR_WR_STARVE_MAX
) (
  input logic         mem_clk0,
  input logic         mem_rst0_n,
  ddr_req_arbiter_if.slave bus
);

  state_t           state;
  logic [LEN_W-1:0] beat_cnt;
  logic             arb_idle;
  logic             sel_rd;
  logic             sel_wr;

  // Arbitration only happens from IDLE once the MIG has calibrated.
  assign arb_idle = (state == ST_IDLE) && bus.init_done;

  ddr_req_prio #(
    .WR_STARVE_MAX (WR_STARVE_MAX)
  ) u_prio (
    .clk    (mem_clk0),
    .rst_n  (mem_rst0_n),
    .rd_req (bus.rd_req),
    .wr_req (bus.wr_req),
    .idle   (arb_idle),
    .wr_gnt (bus.wr_gnt),
    .sel_rd (sel_rd),
    .sel_wr (sel_wr)
  );

  // Burst sequencer: grant, command handshake, beat counting, done pulse.
  always_ff @(posedge mem_clk0 or negedge mem_rst0_n) begin
    if (!mem_rst0_n) begin
      state         <= ST_IDLE;
      beat_cnt      <= '0;
      bus.rd_gnt    <= 1'b0;
      bus.wr_gnt    <= 1'b0;
      bus.rd_done   <= 1'b0;
      bus.wr_done   <= 1'b0;
      bus.cmd_valid <= 1'b0;
      bus.cmd_write <= CMD_READ;
      bus.cmd_addr  <= '0;
      bus.cmd_len   <= '0;
      bus.busy      <= 1'b0;
    end else begin
      bus.rd_gnt  <= 1'b0;
      bus.wr_gnt  <= 1'b0;
      bus.rd_done <= 1'b0;
      bus.wr_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (sel_rd || sel_wr) begin
            bus.rd_gnt    <= sel_rd;
            bus.wr_gnt    <= sel_wr;
            bus.cmd_write <= sel_wr ? CMD_WRITE : CMD_READ;
            bus.cmd_addr  <= sel_wr ? bus.wr_addr : bus.rd_addr;
            bus.cmd_len   <= sel_wr ? bus.wr_len : bus.rd_len;
            bus.busy      <= 1'b1;
            state         <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // First ISSUE cycle carries the grant; cmd_valid follows it.
          if (!bus.cmd_valid) begin
            bus.cmd_valid <= 1'b1;
          end else if (bus.cmd_ready) begin
            bus.cmd_valid <= 1'b0;
            beat_cnt      <= '0;
            state         <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (bus.xfr_beat) begin
            if (beat_cnt == bus.cmd_len) begin
              bus.rd_done <= (bus.cmd_write == CMD_READ);
              bus.wr_done <= (bus.cmd_write == CMD_WRITE);
              state       <= ST_DONE;
            end else begin
              beat_cnt <= beat_cnt + LEN_W'(1);
            end
          end
        end
        ST_DONE: begin
          bus.busy <= 1'b0;
          state    <= ST_IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_req_arbiter.sv
// Self-checking bench for ddr_req_arbiter: directed scenarios plus a random
// request mix, with grant winners predicted by a cycle-level request model.
module tb_ddr_req_arbiter;

  localparam int unsigned ADDR_W = 24;
  localparam int unsigned LEN_W  = 8;
  localparam int unsigned STARVE = 64;

  logic mem_clk0;
  logic mem_rst0_n;

  ddr_req_arbiter_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

  ddr_req_arbiter #(
    .ADDR_W        (ADDR_W),
    .LEN_W         (LEN_W),
    .WR_STARVE_MAX (STARVE)
  ) dut (
    .mem_clk0   (mem_clk0),
    .mem_rst0_n (mem_rst0_n),
    .bus        (bus)
  );

  initial mem_clk0 = 1'b0;
  always #5 mem_clk0 = ~mem_clk0;

  int n_checks;
  int n_fail;

  // Reference model: pending-write age and the winner implied by this cycle's requests.
  int starve_m;
  bit pred_valid;
  bit pred_wr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ctl();
    return {25'd0, bus.rd_gnt, bus.wr_gnt, bus.rd_done, bus.wr_done,
            bus.cmd_valid, bus.cmd_write, bus.busy};
  endfunction

  // Advance one cycle; model observes the cycle at the falling edge, bench resumes 1 after rising edge.
  task automatic tick();
    @(negedge mem_clk0);
    if (!mem_rst0_n) begin
      starve_m   = 0;
      pred_valid = 1'b0;
      pred_wr    = 1'b0;
    end else begin
      if (bus.rd_gnt || bus.wr_gnt)
        chk("grant_winner", {30'd0, bus.rd_gnt, bus.wr_gnt},
            pred_valid ? (pred_wr ? 32'd1 : 32'd2) : 32'd0);
      pred_valid = bus.init_done && (bus.rd_req || bus.wr_req);
      pred_wr    = bus.wr_req && (!bus.rd_req || starve_m >= int'(STARVE));
      if (bus.wr_req && !bus.wr_gnt)
        starve_m = (starve_m < int'(STARVE)) ? starve_m + 1 : int'(STARVE);
      else
        starve_m = 0;
    end
    @(posedge mem_clk0);
    #1;
  endtask

  task automatic wait_gnt(input string tag, output bit wr);
    int n;
    n = 0;
    while (!(bus.rd_gnt || bus.wr_gnt) && n < 60) begin
      tick();
      n++;
    end
    chk({tag, " gnt_seen"}, 32'(bus.rd_gnt || bus.wr_gnt), 32'd1);
    wr = bus.wr_gnt;
  endtask

  // Feed len+1 beats with optional idle gaps; done must follow only the last one.
  task automatic xfer(input int len, input bit wr, input int max_gap, input string tag);
    int early;
    int gap;
    early = 0;
    for (int b = 0; b <= len; b++) begin
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      for (int g = 0; g < gap; g++) begin
        bus.xfr_beat = 1'b0;
        tick();
        if (bus.rd_done || bus.wr_done) early++;
      end
      bus.xfr_beat = 1'b1;
      tick();
      bus.xfr_beat = 1'b0;
      if (b < len && (bus.rd_done || bus.wr_done)) early++;
    end
    chk({tag, " early_done"}, 32'(early), 32'd0);
    chk({tag, " done_pulse"}, {30'd0, bus.rd_done, bus.wr_done}, wr ? 32'd1 : 32'd2);
    chk({tag, " busy_in_done"}, 32'(bus.busy), 32'd1);
    tick();
    chk({tag, " done_clear"}, {29'd0, bus.rd_done, bus.wr_done, bus.busy}, 32'd0);
  endtask

  // Called in the grant cycle: command handshake with optional back-pressure, then beats.
  task automatic serve(input int len, input bit wr, input int ready_dly, input int max_gap,
                       input bit stray, input string tag);
    logic [ADDR_W-1:0] a;
    logic [LEN_W-1:0]  l;
    logic              w;
    int                unstable;
    unstable      = 0;
    bus.cmd_ready = 1'b0;
    bus.xfr_beat  = 1'b0;
    tick();
    chk({tag, " cmd_valid_up"}, 32'(bus.cmd_valid), 32'd1);
    a = bus.cmd_addr;
    l = bus.cmd_len;
    w = bus.cmd_write;
    for (int i = 0; i < ready_dly; i++) begin
      bus.xfr_beat = stray && (i == 0 || $urandom_range(0, 1) == 1);
      tick();
      if (!bus.cmd_valid || bus.cmd_addr !== a || bus.cmd_len !== l || bus.cmd_write !== w)
        unstable++;
    end
    bus.xfr_beat = 1'b0;
    if (ready_dly > 0) chk({tag, " cmd_stable"}, 32'(unstable), 32'd0);
    bus.cmd_ready = 1'b1;
    tick();
    bus.cmd_ready = 1'b0;
    chk({tag, " cmd_valid_drop"}, 32'(bus.cmd_valid), 32'd0);
    xfer(len, wr, max_gap, tag);
  endtask

  initial begin
    bit w;
    int bad;
    int reads;
    bit wr_seen;
    logic [ADDR_W-1:0] ea;
    logic [LEN_W-1:0]  el;

    n_checks = 0;
    n_fail   = 0;
    starve_m = 0;
    pred_valid = 1'b0;
    pred_wr    = 1'b0;
    mem_rst0_n    = 1'b0;
    bus.init_done = 1'b0;
    bus.rd_req    = 1'b0;
    bus.rd_addr   = '0;
    bus.rd_len    = '0;
    bus.wr_req    = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_len    = '0;
    bus.cmd_ready = 1'b0;
    bus.xfr_beat  = 1'b0;

    tick();
    chk("reset_ctl", ctl(), 32'd0);
    chk("reset_cmd_addr", 32'(bus.cmd_addr), 32'd0);
    chk("reset_cmd_len", 32'(bus.cmd_len), 32'd0);
    tick();
    mem_rst0_n = 1'b1;
    tick();

    // No grants while the MIG is uncalibrated, then the read wins.
    bus.rd_req  = 1'b1;
    bus.rd_addr = ADDR_W'($urandom);
    bus.rd_len  = LEN_W'($urandom_range(0, 3));
    bus.wr_req  = 1'b1;
    bus.wr_addr = ADDR_W'($urandom);
    bus.wr_len  = LEN_W'($urandom_range(0, 3));
    bad = 0;
    repeat (20) begin
      tick();
      if (bus.rd_gnt || bus.wr_gnt || bus.cmd_valid || bus.busy) bad++;
    end
    chk("init_hold", 32'(bad), 32'd0);
    bus.init_done = 1'b1;
    tick();
    chk("init_gnt", {30'd0, bus.rd_gnt, bus.wr_gnt}, 32'd2);
    chk("init_cmd_addr", 32'(bus.cmd_addr), 32'(bus.rd_addr));
    bus.rd_req = 1'b0;
    bus.wr_req = 1'b0;
    serve(int'(bus.rd_len), 1'b0, 0, 0, 1'b0, "init");

    // Read only, fixed address, four beats.
    bus.rd_addr = 24'h0FFF00;
    bus.rd_len  = 8'd3;
    bus.rd_req  = 1'b1;
    wait_gnt("rd_only", w);
    bus.rd_req = 1'b0;
    chk("rd_only cmd_addr", 32'(bus.cmd_addr), 32'h000F_FF00);
    chk("rd_only cmd_write", 32'(bus.cmd_write), 32'd0);
    chk("rd_only cmd_len", 32'(bus.cmd_len), 32'd3);
    serve(3, 1'b0, 0, 0, 1'b0, "rd_only");

    // Continuous reads starve a pending write until the guard trips.
    bus.rd_len = '0;
    bus.wr_len = '0;
    bus.rd_req = 1'b1;
    bus.wr_req = 1'b1;
    reads   = 0;
    wr_seen = 1'b0;
    for (int t = 0; t < 40 && !wr_seen; t++) begin
      wait_gnt("starve", w);
      if (w) begin
        wr_seen    = 1'b1;
        bus.wr_req = 1'b0;
      end else begin
        reads++;
      end
      serve(0, w, 0, 0, 1'b0, "starve");
    end
    chk("starve_wr_granted", 32'(wr_seen), 32'd1);
    chk("starve_reads_first", 32'(reads > 1), 32'd1);
    bus.wr_req = 1'b1;
    wait_gnt("after_starve", w);
    chk("after_starve_rd_wins", 32'(w), 32'd0);
    bus.rd_req = 1'b0;
    serve(0, w, 0, 0, 1'b0, "after_starve");
    wait_gnt("after_starve_wr", w);
    chk("after_starve_wr_wins", 32'(w), 32'd1);
    bus.wr_req = 1'b0;
    serve(0, w, 0, 0, 1'b0, "after_starve_wr");

    // Maximum length burst: 256 beats.
    bus.rd_addr = ADDR_W'($urandom);
    bus.rd_len  = 8'hFF;
    bus.rd_req  = 1'b1;
    wait_gnt("len255", w);
    bus.rd_req = 1'b0;
    chk("len255 cmd_len", 32'(bus.cmd_len), 32'hFF);
    serve(255, 1'b0, 0, 0, 1'b0, "len255");

    // Asynchronous reset in the middle of a transfer.
    bus.rd_addr = ADDR_W'($urandom);
    bus.rd_len  = 8'd7;
    bus.rd_req  = 1'b1;
    wait_gnt("rst_mid", w);
    bus.rd_req    = 1'b0;
    bus.cmd_ready = 1'b1;
    tick();
    tick();
    bus.cmd_ready = 1'b0;
    repeat (3) begin
      bus.xfr_beat = 1'b1;
      tick();
    end
    bus.xfr_beat = 1'b0;
    #2 mem_rst0_n = 1'b0;
    #1;
    chk("rst_mid ctl", ctl(), 32'd0);
    chk("rst_mid cmd_addr", 32'(bus.cmd_addr), 32'd0);
    chk("rst_mid cmd_len", 32'(bus.cmd_len), 32'd0);
    bad = 0;
    repeat (2) begin
      tick();
      if (ctl() != 32'd0) bad++;
    end
    mem_rst0_n = 1'b1;
    tick();
    chk("rst_mid quiet", 32'(bad) + ctl(), 32'd0);
    bus.rd_addr = ADDR_W'($urandom);
    bus.rd_len  = 8'd2;
    bus.rd_req  = 1'b1;
    wait_gnt("rst_after", w);
    bus.rd_req = 1'b0;
    chk("rst_after rd_gnt", 32'(w), 32'd0);
    chk("rst_after cmd_addr", 32'(bus.cmd_addr), 32'(bus.rd_addr));
    serve(2, 1'b0, 0, 0, 1'b0, "rst_after");

    // Back-pressure with stray beats while the command is pending.
    bus.wr_addr = ADDR_W'($urandom);
    bus.wr_len  = 8'd3;
    bus.wr_req  = 1'b1;
    wait_gnt("bp", w);
    bus.wr_req = 1'b0;
    chk("bp wr_gnt", 32'(w), 32'd1);
    chk("bp cmd_addr", 32'(bus.cmd_addr), 32'(bus.wr_addr));
    chk("bp cmd_write", 32'(bus.cmd_write), 32'd1);
    serve(3, 1'b1, 10, 0, 1'b1, "bp");

    // Random request mix; losers keep their request held and unchanged.
    for (int it = 0; it < 25; it++) begin
      if (!bus.rd_req && $urandom_range(0, 1) == 1) begin
        bus.rd_req  = 1'b1;
        bus.rd_addr = ADDR_W'($urandom);
        bus.rd_len  = LEN_W'($urandom_range(0, 7));
      end
      if (!bus.wr_req && $urandom_range(0, 1) == 1) begin
        bus.wr_req  = 1'b1;
        bus.wr_addr = ADDR_W'($urandom);
        bus.wr_len  = LEN_W'($urandom_range(0, 7));
      end
      if (!bus.rd_req && !bus.wr_req) begin
        bus.rd_req  = 1'b1;
        bus.rd_addr = ADDR_W'($urandom);
        bus.rd_len  = LEN_W'($urandom_range(0, 7));
      end
      wait_gnt("rand", w);
      ea = w ? bus.wr_addr : bus.rd_addr;
      el = w ? bus.wr_len : bus.rd_len;
      chk("rand cmd_addr", 32'(bus.cmd_addr), 32'(ea));
      chk("rand cmd_len", 32'(bus.cmd_len), 32'(el));
      chk("rand cmd_write", 32'(bus.cmd_write), 32'(w));
      if (w) bus.wr_req = 1'b0;
      else   bus.rd_req = 1'b0;
      serve(int'(el), w, int'($urandom_range(0, 3)), 2, 1'b0, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
